// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and field positions for the L1 data cache controller
//
// Purpose: controller state encoding, address field positions and line width.
// Ports:   none (package).
package dcache_pkg;

  localparam int LINE_W     = 128;
  localparam int TAG_LSB    = 7;   // tag   = addr[31:7]
  localparam int INDEX_LSB  = 4;   // index = addr[6:4]
  localparam int OFFSET_LSB = 2;   // word  = addr[3:2]

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    MREQ   = 3'd2,
    FILL   = 3'd3,
    RETRY  = 3'd4,
    WT     = 3'd5,
    DONE   = 3'd6
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
//
// Purpose: counts i_inc pulses, holding at all-ones instead of wrapping.
// Ports:   i_clk   clock
//          i_clr   synchronous clear (wins over i_inc)
//          i_inc   count one event this cycle
//          o_count current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;
  logic [W-1:0] w_next;

  always_comb begin
    w_next = r_count;
    if (i_inc && (r_count != {W{1'b1}})) begin
      w_next = r_count + W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/dcache_l1_controller.sv
// rtl/dcache_l1_controller.sv - miss/fill/write-through sequencer for the 8-line direct-mapped L1 D-cache
//
// Purpose: latches a CPU load/store, probes the cache array, fetches and installs
//          the line on a miss, retries the probe, and writes every store through
//          to memory (write-allocate, write-through).
// Ports:   i_clk, i_rst                  clock, synchronous active-high reset
//          i_cpu_*  / o_cpu_stall/done   CPU memory-stage request and handshake
//          i_cache_hit / o_cache_*       cache array probe strobes and hit flag
//          o_fill_*                      one-cycle line install into the array
//          o_mem_* / i_mem_*             memory request/ready handshake
//          o_miss_count, o_wt_count      saturating event counters
module dcache_l1_controller #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_W = dcache_pkg::LINE_W,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpu_read,
  input  logic              i_cpu_write,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_stall,
  output logic              o_cpu_done,
  input  logic              i_cache_hit,
  output logic              o_cache_read,
  output logic              o_cache_write,
  output logic [ADDR_W-1:0] o_cache_addr,
  output logic [DATA_W-1:0] o_cache_wdata,
  output logic              o_fill_valid,
  output logic [ADDR_W-1:0] o_fill_addr,
  output logic [LINE_W-1:0] o_fill_data,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ready,
  input  logic [LINE_W-1:0] i_mem_rdata,
  output logic [CNT_W-1:0]  o_miss_count,
  output logic [CNT_W-1:0]  o_wt_count
);

  import dcache_pkg::*;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_is_wr;
  logic              r_retried;   // this request has already been filled once
  logic [LINE_W-1:0] r_line;
  logic              r_cpu_done;
  logic              r_cache_read;
  logic              r_cache_write;
  logic              r_fill_valid;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              w_req;
  logic              w_miss_inc;
  logic              w_wt_inc;
  logic [ADDR_W-1:0] w_line_addr;
  logic [ADDR_W-1:0] w_word_addr;

  assign w_req       = i_cpu_read | i_cpu_write;
  assign w_line_addr = {r_addr[ADDR_W-1:TAG_LSB], r_addr[TAG_LSB-1:INDEX_LSB], {INDEX_LSB{1'b0}}};
  assign w_word_addr = {r_addr[ADDR_W-1:OFFSET_LSB], {OFFSET_LSB{1'b0}}};

  // Only the first miss of a request is counted; the post-fill probe never is.
  assign w_miss_inc = (r_state == LOOKUP) && !i_cache_hit && !r_retried;
  assign w_wt_inc   = (r_state == WT) && i_mem_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_is_wr       <= 1'b0;
      r_retried     <= 1'b0;
      r_line        <= '0;
      r_cpu_done    <= 1'b0;
      r_cache_read  <= 1'b0;
      r_cache_write <= 1'b0;
      r_fill_valid  <= 1'b0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
    end else begin
      r_cpu_done    <= 1'b0;
      r_cache_read  <= 1'b0;
      r_cache_write <= 1'b0;
      r_fill_valid  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_addr        <= i_cpu_addr;
            r_wdata       <= i_cpu_wdata;
            r_is_wr       <= i_cpu_write;   // a store wins when both are raised
            r_retried     <= 1'b0;
            r_cache_read  <= ~i_cpu_write;
            r_cache_write <= i_cpu_write;
            r_state       <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (i_cache_hit) begin
            if (r_is_wr) begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= w_word_addr;
              r_mem_wdata <= r_wdata;
              r_state     <= WT;
            end else begin
              r_cpu_done  <= 1'b1;
              r_state     <= DONE;
            end
          end else if (r_retried) begin
            // Freshly installed line missed again: abandon without completing.
            r_state <= IDLE;
          end else begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= w_line_addr;
            r_state    <= MREQ;
          end
        end
        MREQ: begin
          if (i_mem_ready) begin
            r_line       <= i_mem_rdata;
            r_mem_req    <= 1'b0;
            r_fill_valid <= 1'b1;
            r_state      <= FILL;
          end
        end
        FILL: begin
          r_state <= RETRY;
        end
        RETRY: begin
          r_retried     <= 1'b1;
          r_cache_read  <= ~r_is_wr;
          r_cache_write <= r_is_wr;
          r_state       <= LOOKUP;
        end
        WT: begin
          if (i_mem_ready) begin
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_cpu_done <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && (r_state == LOOKUP) && r_retried) begin
      assert (i_cache_hit)
        else $error("dcache: line at %h missed again after being filled", r_addr);
    end
  end

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .i_clk   (i_clk),
    .i_clr   (i_rst),
    .i_inc   (w_miss_inc),
    .o_count (o_miss_count)
  );

  sat_counter #(.W(CNT_W)) u_wt_cnt (
    .i_clk   (i_clk),
    .i_clr   (i_rst),
    .i_inc   (w_wt_inc),
    .o_count (o_wt_count)
  );

  // Stall is the one combinational output so the pipeline freezes in the request cycle.
  assign o_cpu_stall   = ((r_state == IDLE) && w_req) || ((r_state != IDLE) && !r_cpu_done);
  assign o_cpu_done    = r_cpu_done;
  assign o_cache_read  = r_cache_read;
  assign o_cache_write = r_cache_write;
  assign o_cache_addr  = r_addr;
  assign o_cache_wdata = r_wdata;
  assign o_fill_valid  = r_fill_valid;
  assign o_fill_addr   = w_line_addr;
  assign o_fill_data   = r_line;
  assign o_mem_req     = r_mem_req;
  assign o_mem_we      = r_mem_we;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wdata   = r_mem_wdata;

endmodule
